break_fetch_sequencer: RTL and testbench
========================================

# break_fetch_sequencer

Upstream sequencer for the variable flip selector in the WalkSAT datapath. It accepts one unsatisfied clause (up to NSAT variable IDs) through a valid/ready handshake. For each literal it reads that variable's clause-broken and mask words from the per-variable occupancy memory and presents them to the selector on consecutive cycles with `wren` = 1..NSAT. It then samples the selector's choice and emits the chosen variable ID as a flip request.

## Interface
- `NSAT`, 3, maximum literals per clause
- `NSAT_BITS`, 2, width of literal index and `wren`
- `MAX_CLAUSES_PER_VARIABLE`, 20, width MC of broken/mask words
- `VAR_BITS`, 10, variable ID width and memory address width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clause_valid_i`  in  1  clause offered
- `clause_ready_o`  out  1  sequencer can accept a clause
- `clause_vars_i`  in  NSAT*VAR_BITS  variable IDs; literal k is at `[k*VAR_BITS +: VAR_BITS]`
- `clause_lit_valid_i`  in  NSAT  literal-present mask
- `mem_rd_en_o`  out  1  occupancy memory read strobe
- `mem_addr_o`  out  VAR_BITS  read address (variable ID)
- `mem_rd_data_i`  in  2*MC  `{mask[MC-1:0], broken[MC-1:0]}`, valid the cycle after `mem_rd_en_o`
- `clause_broken_o`  out  MC  to selector `clause_broken_i`
- `mask_bits_o`  out  MC  to selector `mask_bits_i`
- `wren_o`  out  NSAT_BITS  to selector `wren_i`
- `break_values_valid_o`  out  NSAT  to selector `break_values_valid_i`
- `selected_i`  in  NSAT_BITS  from selector `selected_o`
- `flip_valid_o`  out  1  flip request valid
- `flip_ready_i`  in  1  flip request consumed
- `flip_var_o`  out  VAR_BITS  variable to flip
- `flip_lit_o`  out  NSAT_BITS  literal index chosen
- `empty_clause_o`  out  1  one-cycle pulse when a clause with no valid literals is dropped

## Operation
- FSM states: IDLE, PRIME, FEED(k) for k = 1..NSAT, SAMPLE, HOLD.
- IDLE:
  - `clause_ready_o`=1.
  - On `clause_valid_i`, register `clause_vars_i` and `clause_lit_valid_i`.
  - If the literal mask is zero, pulse `empty_clause_o` and stay in IDLE; otherwise go to PRIME.
- PRIME:
  - `wren_o`=0.
  - Issue the read for literal 0: `mem_rd_en_o`=1 only if literal 0 is valid.
- FEED(k):
  - `wren_o`=k.
  - `clause_broken_o`/`mask_bits_o` = memory data for literal k-1. Drive 0 if literal k-1 is not valid.
  - Issue the read for literal k when k<NSAT and literal k is valid.
  - In FEED(NSAT) only, `break_values_valid_o` = registered literal mask; otherwise it is 0.
- SAMPLE:
  - `wren_o`=0.
  - Capture `selected_i`; `flip_var_o` = vars[selected_i], `flip_lit_o` = selected_i.
  - If `selected_i`≥NSAT or selects an invalid literal, instead pick the lowest valid literal.
  - Go to HOLD.
- HOLD:
  - `flip_valid_o`=1, with outputs stable until `flip_ready_i`.
  - On handshake, return to IDLE.
  - `clause_ready_o` is 0 here; there is no overlap between clauses.
- Outside FEED states, `clause_broken_o` and `mask_bits_o` are 0.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE and every output 0, including `clause_ready_o`. `clause_ready_o` rises on the first clock after release.
- Accept cycle to `flip_valid_o`: NSAT+3 cycles (6 at NSAT=3). Minimum clause period is NSAT+4 cycles when `flip_ready_i` is tied high.
- Memory is synchronous with 1-cycle latency. The read issued in state S is consumed in the following FEED state. There is no back-pressure on memory.
- The selector output is combinationally valid the cycle after FEED(NSAT) and is sampled in SAMPLE.
- `flip_valid_o` must not drop until the handshake.
- Asserting `clause_valid_i` outside IDLE has no effect.
- Reset asserted mid-sequence aborts the clause immediately; no partial flip request is emitted.

## Configuration
- `FLIP_COUNT_EN` defined:
  - Adds output `flip_count_o` [31:0], which increments on each `flip_valid_o`&&`flip_ready_i`.
  - It saturates at 32'hFFFF_FFFF and is cleared by reset.
- `FLIP_COUNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- All three literals valid, vars {5,9,12}, memory returns distinct words, selector model returns 1 → `wren_o` sequence 0,1,2,3,0 with matching data; `break_values_valid_o`=3'b111 only at `wren`=3; `flip_var_o`=9 six cycles after accept.
- Literal mask 3'b101 → no read for literal 1; FEED(2) data is 0; `break_values_valid_o`=3'b101; selector returns 1 → fallback `flip_lit_o`=0.
- Literal mask 3'b000 → `empty_clause_o` pulses once, no memory reads, `clause_ready_o` stays 1.
- `flip_ready_i` held low 5 cycles → `flip_valid_o`, `flip_var_o` stable; `clause_ready_o`=0; a second `clause_valid_i` is ignored until the handshake.
- `reset` pulsed low during FEED(2) → all outputs 0 asynchronously; the next clause runs a full correct sequence.
- With `FLIP_COUNT_EN`: 4 completed flips → `flip_count_o`=4; a reset clears it to 0.

Source files
------------

// File: rtl/break_fetch_sequencer_if.sv
// Clause, occupancy-memory, selector and flip-request bundle for break_fetch_sequencer.
// The master modport is the sequencer side; slave is the environment side.
interface break_fetch_sequencer_if #(
  parameter int NSAT = 3,
  parameter int NSAT_BITS = 2,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int VAR_BITS = 10
);
  localparam int MC = MAX_CLAUSES_PER_VARIABLE;

  logic                     clause_valid_i;
  logic                     clause_ready_o;
  logic [NSAT*VAR_BITS-1:0] clause_vars_i;
  logic [NSAT-1:0]          clause_lit_valid_i;

  logic                     mem_rd_en_o;
  logic [VAR_BITS-1:0]      mem_addr_o;
  logic [2*MC-1:0]          mem_rd_data_i;

  logic [MC-1:0]            clause_broken_o;
  logic [MC-1:0]            mask_bits_o;
  logic [NSAT_BITS-1:0]     wren_o;
  logic [NSAT-1:0]          break_values_valid_o;
  logic [NSAT_BITS-1:0]     selected_i;

  logic                     flip_valid_o;
  logic                     flip_ready_i;
  logic [VAR_BITS-1:0]      flip_var_o;
  logic [NSAT_BITS-1:0]     flip_lit_o;
  logic                     empty_clause_o;

  modport master (
    input  clause_valid_i, clause_vars_i, clause_lit_valid_i,
    input  mem_rd_data_i, selected_i, flip_ready_i,
    output clause_ready_o, mem_rd_en_o, mem_addr_o,
    output clause_broken_o, mask_bits_o, wren_o,
    output break_values_valid_o, flip_valid_o,
    output flip_var_o, flip_lit_o, empty_clause_o
  );

  modport slave (
    output clause_valid_i, clause_vars_i, clause_lit_valid_i,
    output mem_rd_data_i, selected_i, flip_ready_i,
    input  clause_ready_o, mem_rd_en_o, mem_addr_o,
    input  clause_broken_o, mask_bits_o, wren_o,
    input  break_values_valid_o, flip_valid_o,
    input  flip_var_o, flip_lit_o, empty_clause_o
  );
endinterface

// File: rtl/break_fetch_sequencer.sv
// WalkSAT break-value fetch sequencer feeding the flip selector.
// Optional FLIP_COUNT_EN adds a saturating 32-bit flip_count_o.
module break_fetch_sequencer #(
  parameter int NSAT = 3,
  parameter int NSAT_BITS = 2,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int VAR_BITS = 10
) (
  input  logic clk,
  input  logic reset,
  break_fetch_sequencer_if.master bus
`ifdef FLIP_COUNT_EN
  ,
  output logic [31:0] flip_count_o
`endif
);
  localparam int MC = MAX_CLAUSES_PER_VARIABLE;

  typedef enum logic [2:0] {
    IDLE, PRIME, FEED, SAMPLE, HOLD
  } state_t;

  state_t state;

  logic [NSAT_BITS-1:0]     k;
  logic [NSAT_BITS-1:0]     nk;
  logic [NSAT_BITS-1:0]     lowest;
  logic [NSAT_BITS-1:0]     pick;
  logic                     last;
  logic [NSAT*VAR_BITS-1:0] vars_q;
  logic [NSAT-1:0]          lit_q;

  logic                     ready_q;
  logic                     rd_en_q;
  logic [VAR_BITS-1:0]      addr_q;
  logic [NSAT_BITS-1:0]     wren_q;
  logic [NSAT-1:0]          bvv_q;
  logic                     feed_en_q;
  logic                     flip_valid_q;
  logic [VAR_BITS-1:0]      flip_var_q;
  logic [NSAT_BITS-1:0]     flip_lit_q;
  logic                     empty_q;

  function automatic logic lit_at(
    input logic [NSAT-1:0]      m,
    input logic [NSAT_BITS-1:0] i
  );
    lit_at = 1'b0;
    for (int j = 0; j < NSAT; j++)
      if (i == NSAT_BITS'(j)) lit_at = m[j];
  endfunction

  function automatic logic [VAR_BITS-1:0] var_at(
    input logic [NSAT*VAR_BITS-1:0] v,
    input logic [NSAT_BITS-1:0]     i
  );
    var_at = '0;
    for (int j = 0; j < NSAT; j++)
      if (i == NSAT_BITS'(j)) var_at = v[j*VAR_BITS +: VAR_BITS];
  endfunction

  // Out-of-range or invalid selector choices fall back to the lowest valid literal.
  always_comb begin
    nk = (state == FEED) ? k + NSAT_BITS'(1) : NSAT_BITS'(1);
    last = (k == NSAT_BITS'(NSAT));
    lowest = '0;
    for (int j = NSAT - 1; j >= 0; j--)
      if (lit_q[j]) lowest = NSAT_BITS'(j);
    pick = lit_at(lit_q, bus.selected_i) ? bus.selected_i : lowest;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      k            <= '0;
      vars_q       <= '0;
      lit_q        <= '0;
      ready_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      wren_q       <= '0;
      bvv_q        <= '0;
      feed_en_q    <= 1'b0;
      flip_valid_q <= 1'b0;
      flip_var_q   <= '0;
      flip_lit_q   <= '0;
      empty_q      <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      empty_q <= 1'b0;
      unique case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && bus.clause_valid_i) begin
            vars_q <= bus.clause_vars_i;
            lit_q  <= bus.clause_lit_valid_i;
            if (bus.clause_lit_valid_i == '0) begin
              empty_q <= 1'b1;
            end else begin
              ready_q <= 1'b0;
              state   <= PRIME;
              rd_en_q <= bus.clause_lit_valid_i[0];
              if (bus.clause_lit_valid_i[0])
                addr_q <= bus.clause_vars_i[VAR_BITS-1:0];
            end
          end
        end
        PRIME, FEED: begin
          if (state == FEED && last) begin
            state     <= SAMPLE;
            wren_q    <= '0;
            feed_en_q <= 1'b0;
            bvv_q     <= '0;
          end else begin
            // Next FEED shows literal nk-1 and prefetches literal nk.
            state     <= FEED;
            k         <= nk;
            wren_q    <= nk;
            feed_en_q <= lit_at(lit_q, nk - NSAT_BITS'(1));
            rd_en_q   <= lit_at(lit_q, nk);
            if (lit_at(lit_q, nk))
              addr_q <= var_at(vars_q, nk);
            bvv_q <= (nk == NSAT_BITS'(NSAT)) ? lit_q : '0;
          end
        end
        SAMPLE: begin
          state        <= HOLD;
          flip_valid_q <= 1'b1;
          flip_var_q   <= var_at(vars_q, pick);
          flip_lit_q   <= pick;
        end
        HOLD: begin
          if (bus.flip_ready_i) begin
            state        <= IDLE;
            flip_valid_q <= 1'b0;
            flip_var_q   <= '0;
            flip_lit_q   <= '0;
            ready_q      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FLIP_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      flip_count_o <= '0;
    else if (flip_valid_q && bus.flip_ready_i && flip_count_o != '1)
      flip_count_o <= flip_count_o + 32'd1;
  end
`endif

  assign bus.clause_ready_o       = ready_q;
  assign bus.mem_rd_en_o          = rd_en_q;
  assign bus.mem_addr_o           = addr_q;
  assign bus.wren_o               = wren_q;
  assign bus.break_values_valid_o = bvv_q;
  assign bus.flip_valid_o         = flip_valid_q;
  assign bus.flip_var_o           = flip_var_q;
  assign bus.flip_lit_o           = flip_lit_q;
  assign bus.empty_clause_o       = empty_q;
  assign bus.clause_broken_o =
    feed_en_q ? bus.mem_rd_data_i[MC-1:0] : '0;
  assign bus.mask_bits_o =
    feed_en_q ? bus.mem_rd_data_i[2*MC-1:MC] : '0;

endmodule

// File: tb/tb_break_fetch_sequencer.sv
// Scoreboard bench for break_fetch_sequencer.
// Memory word for var v: broken = 0x1000+v, mask = 0x2000+v.
module tb_break_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  break_fetch_sequencer_if bus ();
`ifdef FLIP_COUNT_EN
  logic [31:0] flip_count;
`endif

  break_fetch_sequencer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef FLIP_COUNT_EN
    ,
    .flip_count_o (flip_count)
`endif
  );

  typedef struct {
    logic [1:0]  wren;
    logic [19:0] b;
    logic [19:0] m;
    logic [2:0]  bvv;
  } feed_t;

  typedef struct {
    logic [9:0] v;
    logic [1:0] l;
    int         rise;
  } flip_t;

  feed_t      feed_q[$];
  flip_t      flip_q[$];
  logic [9:0] rd_q[$];
  int exp_empty = 0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc = 0;
  int rise = 0;
  logic fv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.mem_rd_en_o)
      bus.mem_rd_data_i <= {20'h02000 + 20'(bus.mem_addr_o),
                            20'h01000 + 20'(bus.mem_addr_o)};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_feed(input logic [1:0] w, input logic [19:0] b,
                           input logic [19:0] m, input logic [2:0] bvv);
    feed_t f;
    f.wren = w; f.b = b; f.m = m; f.bvv = bvv;
    feed_q.push_back(f);
  endtask

  task automatic push_flip(input logic [9:0] v, input logic [1:0] l);
    flip_t f;
    f.v = v; f.l = l; f.rise = acc + 6;
    flip_q.push_back(f);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    feed_t f;
    flip_t p;
    if (bus.mem_rd_en_o) begin
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_extra: got addr %0d expected no read", bus.mem_addr_o);
      end else chk("rd_addr", 64'(bus.mem_addr_o), 64'(rd_q.pop_front()));
    end
    if (bus.wren_o != 2'd0) begin
      if (feed_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL feed_extra: got wren %0d expected 0", bus.wren_o);
      end else begin
        f = feed_q.pop_front();
        chk("wren", 64'(bus.wren_o), 64'(f.wren));
        chk("broken", 64'(bus.clause_broken_o), 64'(f.b));
        chk("mask", 64'(bus.mask_bits_o), 64'(f.m));
        chk("bvv", 64'(bus.break_values_valid_o), 64'(f.bvv));
      end
    end else begin
      chk("idle_zero", 64'({bus.clause_broken_o, bus.mask_bits_o,
                            bus.break_values_valid_o}), 64'd0);
    end
    if (bus.flip_valid_o && !fv_prev) rise = cyc;
    if (bus.flip_valid_o && bus.flip_ready_i) begin
      if (flip_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL flip_extra: got var %0d expected no flip", bus.flip_var_o);
      end else begin
        p = flip_q.pop_front();
        chk("flip_var", 64'(bus.flip_var_o), 64'(p.v));
        chk("flip_lit", 64'(bus.flip_lit_o), 64'(p.l));
        chk("latency", 64'(rise), 64'(p.rise));
      end
    end
    if (bus.empty_clause_o) begin
      tests++;
      if (exp_empty == 0) begin
        fails++;
        $display("FAIL empty_extra: got pulse expected none");
      end else exp_empty--;
    end
    fv_prev = bus.flip_valid_o;
  end

  task automatic offer(input logic [9:0] v0, input logic [9:0] v1,
                       input logic [9:0] v2, input logic [2:0] lit,
                       input logic [1:0] sel);
    int n;
    @(posedge clk); #1;
    bus.clause_vars_i = {v2, v1, v0};
    bus.clause_lit_valid_i = lit;
    bus.selected_i = sel;
    bus.clause_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.clause_ready_o && n < 40) begin
      @(negedge clk); n++;
    end
    if (n >= 40) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
    end
    acc = cyc;
    @(posedge clk); #1;
    bus.clause_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!(flip_q.size() == 0 && bus.clause_ready_o) && n < 40);
    if (n >= 40) begin
      tests++; fails++;
      $display("FAIL done_timeout: got pending %0d expected 0", flip_q.size());
    end
  endtask

  task automatic run_t1(input logic [1:0] sel, input logic [9:0] ev,
                        input logic [1:0] el);
    rd_q.push_back(10'd5); rd_q.push_back(10'd9); rd_q.push_back(10'd12);
    push_feed(2'd1, 20'h01005, 20'h02005, 3'b000);
    push_feed(2'd2, 20'h01009, 20'h02009, 3'b000);
    push_feed(2'd3, 20'h0100C, 20'h0200C, 3'b111);
    offer(10'd5, 10'd9, 10'd12, 3'b111, sel);
    push_flip(ev, el);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.clause_valid_i = 1'b0;
    bus.clause_vars_i = '0;
    bus.clause_lit_valid_i = '0;
    bus.selected_i = '0;
    bus.flip_ready_i = 1'b1;
    bus.mem_rd_data_i = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 64'(bus.clause_ready_o), 64'd0);
    chk("rst_rd_en", 64'(bus.mem_rd_en_o), 64'd0);
    chk("rst_wren", 64'(bus.wren_o), 64'd0);
    chk("rst_flip_valid", 64'(bus.flip_valid_o), 64'd0);
    chk("rst_empty", 64'(bus.empty_clause_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_before_clk", 64'(bus.clause_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_clk", 64'(bus.clause_ready_o), 64'd1);

    // All literals valid, selector picks literal 1.
    run_t1(2'd1, 10'd9, 2'd1);

    // Mask 101: no read for literal 1, invalid choice falls back to 0.
    rd_q.push_back(10'd7); rd_q.push_back(10'd20);
    push_feed(2'd1, 20'h01007, 20'h02007, 3'b000);
    push_feed(2'd2, 20'h00000, 20'h00000, 3'b000);
    push_feed(2'd3, 20'h01014, 20'h02014, 3'b101);
    offer(10'd7, 10'd3, 10'd20, 3'b101, 2'd1);
    push_flip(10'd7, 2'd0);
    wait_done();

    // Mask 110 with out-of-range selector 3: lowest valid is literal 1.
    rd_q.push_back(10'd2); rd_q.push_back(10'd3);
    push_feed(2'd1, 20'h00000, 20'h00000, 3'b000);
    push_feed(2'd2, 20'h01002, 20'h02002, 3'b000);
    push_feed(2'd3, 20'h01003, 20'h02003, 3'b110);
    offer(10'd1, 10'd2, 10'd3, 3'b110, 2'd3);
    push_flip(10'd2, 2'd1);
    wait_done();

    // Empty clause.
    exp_empty = 1;
    offer(10'd1, 10'd2, 10'd3, 3'b000, 2'd0);
    @(negedge clk); #1;
    chk("empty_ready", 64'(bus.clause_ready_o), 64'd1);
    chk("empty_seen", 64'(exp_empty), 64'd0);
    @(negedge clk); #1;
    chk("empty_one_pulse", 64'(bus.empty_clause_o), 64'd0);

    // Flip back-pressure with a second clause offered during HOLD.
    bus.flip_ready_i = 1'b0;
    rd_q.push_back(10'd100); rd_q.push_back(10'd200); rd_q.push_back(10'd300);
    push_feed(2'd1, 20'h01064, 20'h02064, 3'b000);
    push_feed(2'd2, 20'h010C8, 20'h020C8, 3'b000);
    push_feed(2'd3, 20'h0112C, 20'h0212C, 3'b111);
    offer(10'd100, 10'd200, 10'd300, 3'b111, 2'd2);
    push_flip(10'd300, 2'd2);
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!bus.flip_valid_o && n < 40);
    if (n >= 40) begin
      tests++; fails++;
      $display("FAIL hold_timeout: got flip_valid 0 expected 1");
    end
    bus.clause_vars_i = {10'd3, 10'd2, 10'd1};
    bus.clause_lit_valid_i = 3'b111;
    bus.clause_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold_valid", 64'(bus.flip_valid_o), 64'd1);
      chk("hold_var", 64'(bus.flip_var_o), 64'd300);
      chk("hold_ready", 64'(bus.clause_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    bus.clause_valid_i = 1'b0;
    bus.flip_ready_i = 1'b1;
    wait_done();

    // Reset during FEED(2) aborts the clause.
    rd_q.push_back(10'd5); rd_q.push_back(10'd9);
    push_feed(2'd1, 20'h01005, 20'h02005, 3'b000);
    offer(10'd5, 10'd9, 10'd12, 3'b111, 2'd0);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.wren_o != 2'd2 && n < 20);
    chk("reach_feed2", 64'(bus.wren_o), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(bus.clause_ready_o), 64'd0);
    chk("abort_rd_en", 64'(bus.mem_rd_en_o), 64'd0);
    chk("abort_wren", 64'(bus.wren_o), 64'd0);
    chk("abort_data", 64'({bus.clause_broken_o, bus.mask_bits_o}), 64'd0);
    chk("abort_bvv", 64'(bus.break_values_valid_o), 64'd0);
    chk("abort_flip", 64'(bus.flip_valid_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_t1(2'd2, 10'd12, 2'd2);

`ifdef FLIP_COUNT_EN
    run_t1(2'd0, 10'd5, 2'd0);
    run_t1(2'd1, 10'd9, 2'd1);
    run_t1(2'd2, 10'd12, 2'd2);
    chk("flip_count", 64'(flip_count), 64'd4);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("flip_count_rst", 64'(flip_count), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("drain_rd", 64'(rd_q.size()), 64'd0);
    chk("drain_feed", 64'(feed_q.size()), 64'd0);
    chk("drain_flip", 64'(flip_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
